// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single main-memory port between the I$ and D$ miss paths.
// Each cache may have one outstanding miss. The misses are captured, granted
// one at a time, and delayed by a programmable request latency. The arbiter
// then drives the memory request and returns the line, or a bus error, to the
// requesting cache.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   - when both caches are pending, grant the one not served last
//   undefined - fixed priority, D$ wins when both are pending
//
// Payload: memory_request_t is carried as a flat packed vector of INFO_WIDTH
// bits. The arbiter never looks inside it; the address field sits wherever the
// core's packing puts it.
//
// Handshake: req_mm_valid is asserted in MEM_REQ and held, with req_mm_info
// stable, until the cycle that rsp_mm_valid strobes. That cycle completes the
// transaction, and req_mm_valid drops combinationally in that same cycle.
// There is no separate ready signal; the response strobe is the acceptance.
// rsp_valid_miss is a one-cycle strobe with no back-pressure.
//
// Ports:
//   clock, reset                 - clock; synchronous active-high reset
//   icache_req_valid_miss/info   - I$ miss pulse and payload
//   dcache_req_valid_miss/info   - D$ miss pulse and payload
//   req_mm_valid/info            - request to main memory
//   rsp_mm_valid/data/bus_error  - memory response strobe, line, error
//   rsp_valid_miss               - one-cycle response to the caches
//   rsp_cache_id                 - response destination: 0 = I$, 1 = D$
//   rsp_data_miss, rsp_bus_error - returned line and error flag
//   arb_busy                     - state is not IDLE
//   dbg_state                    - current FSM state (0 IDLE, 1 DELAY,
//                                  2 MEM_REQ, 3 RESP)
// -----------------------------------------------------------------------------
`ifndef LATENCY_MM_REQ
`define LATENCY_MM_REQ 4
`endif
`ifndef DCACHE_LINE_WIDTH
`define DCACHE_LINE_WIDTH 128
`endif

module mem_arbiter #(
  parameter int LATENCY_REQ = `LATENCY_MM_REQ,
  parameter int LINE_WIDTH  = `DCACHE_LINE_WIDTH,
  parameter int INFO_WIDTH  = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  icache_req_valid_miss,
  input  logic [INFO_WIDTH-1:0] icache_req_info_miss,
  input  logic                  dcache_req_valid_miss,
  input  logic [INFO_WIDTH-1:0] dcache_req_info_miss,
  output logic                  req_mm_valid,
  output logic [INFO_WIDTH-1:0] req_mm_info,
  input  logic                  rsp_mm_valid,
  input  logic [LINE_WIDTH-1:0] rsp_mm_data,
  input  logic                  rsp_mm_bus_error,
  output logic                  rsp_valid_miss,
  output logic                  rsp_cache_id,
  output logic [LINE_WIDTH-1:0] rsp_data_miss,
  output logic                  rsp_bus_error,
  output logic                  arb_busy,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_MEM_REQ = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(LATENCY_REQ) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY_REQ - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_pend_i;
  logic                    r_pend_d;
  logic [INFO_WIDTH-1:0]   r_info_i;
  logic [INFO_WIDTH-1:0]   r_info_d;
  logic [INFO_WIDTH-1:0]   r_req_info;
  logic                    r_grant_id;
  logic                    r_rsp_id;
  logic [LINE_WIDTH-1:0]   r_rsp_data;
  logic                    r_rsp_err;
  logic                    w_win;
  logic                    w_grant;
  logic                    w_rsp_take;
  logic                    w_clr_i;
  logic                    w_clr_d;

  assign w_grant    = (r_state == ST_IDLE) && (r_pend_i || r_pend_d);
  assign w_rsp_take = (r_state == ST_MEM_REQ) && rsp_mm_valid;
  assign w_clr_i    = w_rsp_take && !r_grant_id;
  assign w_clr_d    = w_rsp_take && r_grant_id;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_id;

  always_comb begin
    w_win = r_pend_d;
    if (r_pend_i && r_pend_d) w_win = !r_last_id;
  end

  always_ff @(posedge clock) begin
    if (reset)        r_last_id <= 1'b0;
    else if (w_grant) r_last_id <= w_win;
  end
`else
  // D$ wins whenever it is pending; an I$ grant already made is untouched
  // because arbitration only happens in IDLE.
  always_comb begin
    w_win = r_pend_d;
  end
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (r_pend_i || r_pend_d) w_next = ST_DELAY;
      ST_DELAY:   if (r_cnt == CNT_LAST)    w_next = ST_MEM_REQ;
      ST_MEM_REQ: if (rsp_mm_valid)         w_next = ST_RESP;
      ST_RESP:                              w_next = ST_IDLE;
      default:                              w_next = ST_IDLE;
    endcase
  end

  // Pending capture. A new pulse arriving in the same cycle that the served
  // cache's pending bit clears wins, so that request is not lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend_i <= 1'b0;
      r_pend_d <= 1'b0;
      r_info_i <= '0;
      r_info_d <= '0;
    end else begin
      if (icache_req_valid_miss && (!r_pend_i || w_clr_i)) begin
        r_pend_i <= 1'b1;
        r_info_i <= icache_req_info_miss;
      end else if (w_clr_i) begin
        r_pend_i <= 1'b0;
      end
      if (dcache_req_valid_miss && (!r_pend_d || w_clr_d)) begin
        r_pend_d <= 1'b1;
        r_info_d <= dcache_req_info_miss;
      end else if (w_clr_d) begin
        r_pend_d <= 1'b0;
      end
    end
  end

  // Grant, delay counter and response capture
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt      <= '0;
      r_req_info <= '0;
      r_grant_id <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_req_info <= w_win ? r_info_d : r_info_i;
        r_grant_id <= w_win;
        r_cnt      <= '0;
      end
      // Saturating count: the counter never wraps.
      if ((r_state == ST_DELAY) && (r_cnt != CNT_LAST)) r_cnt <= r_cnt + 1'b1;
      if (w_rsp_take) begin
        r_rsp_data <= rsp_mm_bus_error ? '0 : rsp_mm_data;
        r_rsp_err  <= rsp_mm_bus_error;
        r_rsp_id   <= r_grant_id;
      end
    end
  end

  assign req_mm_valid   = (r_state == ST_MEM_REQ) && !rsp_mm_valid;
  assign req_mm_info    = r_req_info;
  assign rsp_valid_miss = (r_state == ST_RESP);
  assign rsp_cache_id   = r_rsp_id;
  assign rsp_data_miss  = r_rsp_data;
  assign rsp_bus_error  = r_rsp_err;
  assign arb_busy       = (r_state != ST_IDLE);
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with LATENCY_REQ=4, a 64-bit line and a
// 32-bit payload whose address is the whole payload. The expectations for the
// contention sequence depend on whether MEM_ARB_ROUND_ROBIN_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int LAT = 4;
  localparam int LW  = 64;
  localparam int IW  = 32;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          icache_req_valid_miss = 1'b0;
  logic [IW-1:0] icache_req_info_miss = '0;
  logic          dcache_req_valid_miss = 1'b0;
  logic [IW-1:0] dcache_req_info_miss = '0;
  logic          req_mm_valid;
  logic [IW-1:0] req_mm_info;
  logic          rsp_mm_valid = 1'b0;
  logic [LW-1:0] rsp_mm_data = '0;
  logic          rsp_mm_bus_error = 1'b0;
  logic          rsp_valid_miss;
  logic          rsp_cache_id;
  logic [LW-1:0] rsp_data_miss;
  logic          rsp_bus_error;
  logic          arb_busy;
  logic [1:0]    dbg_state;

  always #5 clock = ~clock;

  mem_arbiter #(
    .LATENCY_REQ(LAT),
    .LINE_WIDTH (LW),
    .INFO_WIDTH (IW)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .icache_req_valid_miss(icache_req_valid_miss),
    .icache_req_info_miss (icache_req_info_miss),
    .dcache_req_valid_miss(dcache_req_valid_miss),
    .dcache_req_info_miss (dcache_req_info_miss),
    .req_mm_valid         (req_mm_valid),
    .req_mm_info          (req_mm_info),
    .rsp_mm_valid         (rsp_mm_valid),
    .rsp_mm_data          (rsp_mm_data),
    .rsp_mm_bus_error     (rsp_mm_bus_error),
    .rsp_valid_miss       (rsp_valid_miss),
    .rsp_cache_id         (rsp_cache_id),
    .rsp_data_miss        (rsp_data_miss),
    .rsp_bus_error        (rsp_bus_error),
    .arb_busy             (arb_busy),
    .dbg_state            (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  // Entry = {expected rsp_cache_id, expected req_mm_info}, in grant order.
  logic [IW:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_total++;
    n_fail++;
    $error("FAIL %s: observed none expected an entry", tag);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic do_i, input logic do_d,
                       input logic [IW-1:0] a_i, input logic [IW-1:0] a_d);
    icache_req_valid_miss = do_i;
    dcache_req_valid_miss = do_d;
    if (do_i) icache_req_info_miss = a_i;
    if (do_d) dcache_req_info_miss = a_d;
    step();
    icache_req_valid_miss = 1'b0;
    dcache_req_valid_miss = 1'b0;
    // Junk payload while valid is low must never be captured.
    icache_req_info_miss  = 32'hBAD0_0001;
    dcache_req_info_miss  = 32'hBAD0_0002;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!req_mm_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  // Serve one memory transaction: wait for the request, strobe the response
  // 'gap' cycles later, then check the response against the scoreboard.
  // Optionally pulse a new miss from cache rp_id in the strobe cycle.
  task automatic mem_transact(input int exp_wait, input int gap,
                              input logic [LW-1:0] data, input logic err,
                              input logic rp_en, input logic rp_id,
                              input logic [IW-1:0] rp_addr);
    int n;
    logic [IW:0] e;
    wait_req(n);
    check("req_seen", req_mm_valid, 1);
    if (!req_mm_valid) return;
    check("req_wait", n, exp_wait);
    if (exp_q.size() == 0) begin
      fail_now("exp_q_empty");
      return;
    end
    e = exp_q.pop_front();
    check("req_info", req_mm_info, e[IW-1:0]);
    for (int k = 0; k < gap; k++) begin
      step();
      check("req_hold", req_mm_valid, 1);
      check("req_info_hold", req_mm_info, e[IW-1:0]);
    end
    rsp_mm_valid     = 1'b1;
    rsp_mm_data      = data;
    rsp_mm_bus_error = err;
    if (rp_en && rp_id)  begin dcache_req_valid_miss = 1'b1; dcache_req_info_miss = rp_addr; end
    if (rp_en && !rp_id) begin icache_req_valid_miss = 1'b1; icache_req_info_miss = rp_addr; end
    #1;
    check("req_drop", req_mm_valid, 0);
    step();
    rsp_mm_valid          = 1'b0;
    rsp_mm_data           = '0;
    rsp_mm_bus_error      = 1'b0;
    icache_req_valid_miss = 1'b0;
    dcache_req_valid_miss = 1'b0;
    check("rsp_valid", rsp_valid_miss, 1);
    check("rsp_id", rsp_cache_id, e[IW]);
    check("rsp_data", rsp_data_miss, err ? 64'h0 : data);
    check("rsp_err", rsp_bus_error, err);
    step();
    check("rsp_one_shot", rsp_valid_miss, 0);
  endtask

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic        RR_MODE  = 1'b1;
  localparam logic        RP2_ID   = 1'b0;
  localparam logic [31:0] RP2_ADDR = 32'h0000_4100;
`else
  localparam logic        RR_MODE  = 1'b0;
  localparam logic        RP2_ID   = 1'b1;
  localparam logic [31:0] RP2_ADDR = 32'h0000_3200;
`endif

  // ---------------- stimulus ----------------
  initial begin
    int n;

    // Reset state
    reset = 1'b1;
    step();
    step();
    check("rst_req_valid", req_mm_valid, 0);
    check("rst_req_info", req_mm_info, 0);
    check("rst_rsp_valid", rsp_valid_miss, 0);
    check("rst_rsp_id", rsp_cache_id, 0);
    check("rst_rsp_data", rsp_data_miss, 0);
    check("rst_rsp_err", rsp_bus_error, 0);
    check("rst_busy", arb_busy, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    step();

    // Single I$ miss with exact cycle timing (pulse in cycle 0)
    pulse(1'b1, 1'b0, 32'h0000_1000, 32'h0);      // now cycle 1
    check("t1_busy_c1", arb_busy, 0);
    step();                                        // cycle 2
    check("t1_busy_c2", arb_busy, 1);
    check("t1_state_c2", dbg_state, 1);
    wait_req(n);                                   // expect cycle 6
    check("t1_req_cycle", n, 4);
    check("t1_req_info", req_mm_info, 32'h0000_1000);
    step();
    step();                                        // cycle 8
    check("t1_req_c8", req_mm_valid, 1);
    step();                                        // cycle 9: strobe
    rsp_mm_valid = 1'b1;
    rsp_mm_data  = 64'hDEAD_BEEF_0123_4567;
    #1;
    check("t1_req_drop", req_mm_valid, 0);
    step();                                        // cycle 10
    rsp_mm_valid = 1'b0;
    rsp_mm_data  = '0;
    check("t1_rsp_valid", rsp_valid_miss, 1);
    check("t1_rsp_id", rsp_cache_id, 0);
    check("t1_rsp_data", rsp_data_miss, 64'hDEAD_BEEF_0123_4567);
    check("t1_rsp_err", rsp_bus_error, 0);
    check("t1_busy_c10", arb_busy, 1);
    step();                                        // cycle 11
    check("t1_busy_c11", arb_busy, 0);
    check("t1_rsp_c11", rsp_valid_miss, 0);

    // Simultaneous I$ + D$: D$ first in both builds (last served was I$)
    exp_q.push_back({1'b1, 32'h0000_2000});
    exp_q.push_back({1'b0, 32'h0000_2100});
    pulse(1'b1, 1'b1, 32'h0000_2100, 32'h0000_2000);
    mem_transact(5, 1, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b0, 32'h0);
    mem_transact(5, 2, 64'h5555_6666_7777_8888, 1'b0, 1'b0, 1'b0, 32'h0);

    // Continuous contention; the served cache re-requests in the strobe cycle
    if (RR_MODE) begin
      exp_q.push_back({1'b1, 32'h0000_3000});
      exp_q.push_back({1'b0, 32'h0000_4000});
      exp_q.push_back({1'b1, 32'h0000_3100});
      exp_q.push_back({1'b0, 32'h0000_4100});
    end else begin
      exp_q.push_back({1'b1, 32'h0000_3000});
      exp_q.push_back({1'b1, 32'h0000_3100});
      exp_q.push_back({1'b1, 32'h0000_3200});
      exp_q.push_back({1'b0, 32'h0000_4000});
    end
    pulse(1'b1, 1'b1, 32'h0000_4000, 32'h0000_3000);
    mem_transact(5, 1, 64'hA0A0_0000_0000_0001, 1'b0, 1'b1, 1'b1, 32'h0000_3100);
    mem_transact(5, 1, 64'hA0A0_0000_0000_0002, 1'b0, 1'b1, RP2_ID, RP2_ADDR);
    mem_transact(5, 0, 64'hA0A0_0000_0000_0003, 1'b0, 1'b0, 1'b0, 32'h0);
    mem_transact(5, 3, 64'hA0A0_0000_0000_0004, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t3_q_drained", exp_q.size(), 0);

    // Bus error: data forced to zero, pending cleared, next request normal
    exp_q.push_back({1'b0, 32'h0000_5000});
    pulse(1'b1, 1'b0, 32'h0000_5000, 32'h0);
    mem_transact(5, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    step();
    check("t4_idle_after_err", arb_busy, 0);
    exp_q.push_back({1'b1, 32'h0000_6000});
    pulse(1'b0, 1'b1, 32'h0, 32'h0000_6000);
    mem_transact(5, 0, 64'h0BAD_CAFE_0000_6000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset for one cycle while in MEM_REQ
    pulse(1'b1, 1'b0, 32'h0000_7000, 32'h0);
    wait_req(n);
    check("t5_req_seen", req_mm_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_req_after_rst", req_mm_valid, 0);
    check("t5_busy_after_rst", arb_busy, 0);
    check("t5_state_after_rst", dbg_state, 0);
    check("t5_info_after_rst", req_mm_info, 0);
    rsp_mm_valid = 1'b1;
    rsp_mm_data  = 64'h7777_7777_7777_7777;
    step();
    rsp_mm_valid = 1'b0;
    rsp_mm_data  = '0;
    for (int k = 0; k < 4; k++) begin
      check("t5_no_rsp", rsp_valid_miss, 0);
      check("t5_no_busy", arb_busy, 0);
      step();
    end

    // Second D$ pulse while the first is pending is ignored
    exp_q.push_back({1'b1, 32'h0000_8000});
    pulse(1'b0, 1'b1, 32'h0, 32'h0000_8000);      // cycle 1
    pulse(1'b0, 1'b1, 32'h0, 32'h0000_8800);      // cycle 2
    mem_transact(4, 1, 64'h8888_0000_0000_8000, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      check("t6_single_rsp", rsp_valid_miss, 0);
      check("t6_no_req", req_mm_valid, 0);
      step();
    end
    check("t6_q_drained", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
